// File: rtl/rf_arb_pkg.sv
// -----------------------------------------------------------------------------
// rf_arb_pkg
// Shared constants for the register-file write arbiter:
//   - requester indices (execute, load, debug)
//   - default parameter values for NREQ / AW / DW
//   - width of the grant_id field
// -----------------------------------------------------------------------------
package rf_arb_pkg;

  // Requester slots on the shared write port
  localparam int REQ_EXEC = 0;
  localparam int REQ_LOAD = 1;
  localparam int REQ_DBG  = 2;

  // Default geometry
  localparam int RF_NREQ = 3;
  localparam int RF_AW   = 5;
  localparam int RF_DW   = 32;

  // Width of the registered grant index
  localparam int GID_W   = 2;

endpackage : rf_arb_pkg

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Generic N-way round-robin arbiter, purely combinational.
// The search starts at ptr_i and wraps; the first valid requester wins.
//
// Ports:
//   valid_i [N-1:0]  request vector
//   ptr_i   [PW-1:0] index at which the search starts
//   grant_o [N-1:0]  one-hot grant (all zero when nothing is valid)
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o
);

  logic [N-1:0] mask;
  logic [N-1:0] req_hi;
  logic [N-1:0] gnt_hi;
  logic [N-1:0] gnt_all;

  // Requesters at or above the pointer get first pick
  for (genvar j = 0; j < N; j++) begin : g_mask
    assign mask[j] = (PW'(j) >= ptr_i);
  end

  assign req_hi  = valid_i & mask;

  // x & -x isolates the lowest set bit
  assign gnt_hi  = req_hi  & (~req_hi  + N'(1));
  assign gnt_all = valid_i & (~valid_i + N'(1));

  // Nothing at/above the pointer: wrap to the lowest valid index
  assign grant_o = (|req_hi) ? gnt_hi : gnt_all;

endmodule : rr_arbiter

// File: rtl/rf_write_arbiter.sv
// -----------------------------------------------------------------------------
// rf_write_arbiter
// Shares the single write port of the 32x32 integer register file between
// NREQ writeback sources (execute, load return, debug/NoC) and keeps a
// per-register pending-load scoreboard for decode hazard detection.
//
// Build option:
//   RF_ARB_RR_EN defined   -> round-robin arbitration (rr_arbiter instance,
//                             pointer register)
//   RF_ARB_RR_EN undefined -> fixed priority, lowest index wins; no pointer
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      per-requester handshake
//   req_addr/req_data        packed per-requester address/data
//   reg_write, wa,           registered write port to the register file
//   data_write, grant_id     (latency 1 from handshake)
//   sb_set, sb_addr          load-issue: mark register pending
//   chk_ra1, chk_ra2         decode source registers
//   hazard                   combinational: a source register is pending
//   busy_mask                scoreboard state
//   sb_err                   sticky: set issued to an already-busy register
// -----------------------------------------------------------------------------
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int NREQ   = RF_NREQ,
  parameter int AW     = RF_AW,
  parameter int DW     = RF_DW,
  parameter int SB_REQ = REQ_LOAD
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic                 reg_write,
  output logic [AW-1:0]        wa,
  output logic [DW-1:0]        data_write,
  output logic [GID_W-1:0]     grant_id,
  input  logic                 sb_set,
  input  logic [AW-1:0]        sb_addr,
  input  logic [AW-1:0]        chk_ra1,
  input  logic [AW-1:0]        chk_ra2,
  output logic                 hazard,
  output logic [(1<<AW)-1:0]   busy_mask,
  output logic                 sb_err
);

  localparam int NREG = 1 << AW;

  logic [NREQ-1:0]  grant;
  logic             hs;
  logic [GID_W-1:0] win_idx;
  logic [AW-1:0]    hs_addr;
  logic [DW-1:0]    hs_data;

  logic             reg_write_d, reg_write_q;
  logic [AW-1:0]    wa_d,        wa_q;
  logic [DW-1:0]    data_d,      data_q;
  logic [GID_W-1:0] gid_d,       gid_q;
  logic [NREG-1:0]  busy_d,      busy_q;
  logic             sb_err_d,    sb_err_q;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
`ifdef RF_ARB_RR_EN
  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTR_W-1:0] ptr_d, ptr_q;

  rr_arbiter #(
    .N  (NREQ),
    .PW (PTR_W)
  ) u_rr (
    .valid_i (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant)
  );

  // Pointer moves past the winner; holds when nothing transfers
  always_comb begin
    ptr_d = ptr_q;
    if (hs) begin
      if (win_idx == GID_W'(NREQ - 1)) ptr_d = '0;
      else                             ptr_d = PTR_W'(win_idx) + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`else
  // Fixed priority: lowest set bit of the valid vector
  assign grant = req_valid & (~req_valid + NREQ'(1));
`endif

  assign req_ready = grant;
  assign hs        = |grant;

  // One-hot grant -> index, address and data of the winner
  always_comb begin
    win_idx = '0;
    hs_addr = '0;
    hs_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        win_idx = GID_W'(i);
        hs_addr = req_addr[i*AW +: AW];
        hs_data = req_data[i*DW +: DW];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    wa_d   = wa_q;
    data_d = data_q;
    gid_d  = gid_q;
    // Writes to x0 are accepted but never reach the register file
    reg_write_d = hs && (hs_addr != '0);
    if (hs) begin
      wa_d   = hs_addr;
      data_d = hs_data;
      gid_d  = win_idx;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard next-state
  // ---------------------------------------------------------------------------
  logic sb_clr;
  logic sb_do_set;

  assign sb_clr    = hs && (win_idx == GID_W'(SB_REQ)) && (hs_addr != '0);
  assign sb_do_set = sb_set && (sb_addr != '0);

  always_comb begin
    busy_d   = busy_q;
    sb_err_d = sb_err_q;
    // Clear first, then set, so a same-address set overrides the clear
    if (sb_clr)    busy_d[hs_addr] = 1'b0;
    if (sb_do_set) busy_d[sb_addr] = 1'b1;
    // A bit being retired in this same cycle is not a double-issue
    if (sb_do_set && busy_q[sb_addr] && !(sb_clr && (hs_addr == sb_addr)))
      sb_err_d = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_q <= 1'b0;
      wa_q        <= '0;
      data_q      <= '0;
      gid_q       <= '0;
      busy_q      <= '0;
      sb_err_q    <= 1'b0;
    end else begin
      reg_write_q <= reg_write_d;
      wa_q        <= wa_d;
      data_q      <= data_d;
      gid_q       <= gid_d;
      busy_q      <= busy_d;
      sb_err_q    <= sb_err_d;
    end
  end

  assign reg_write  = reg_write_q;
  assign wa         = wa_q;
  assign data_write = data_q;
  assign grant_id   = gid_q;
  assign busy_mask  = busy_q;
  assign sb_err     = sb_err_q;

  // x0 is never set in busy_q, so no explicit x0 exclusion is needed here
  assign hazard = busy_q[chk_ra1] | busy_q[chk_ra2];

endmodule : rf_write_arbiter

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic        reg_write;
  logic [4:0]  wa;
  logic [31:0] data_write;
  logic [1:0]  grant_id;
  logic        sb_set;
  logic [4:0]  sb_addr;
  logic [4:0]  chk_ra1;
  logic [4:0]  chk_ra2;
  logic        hazard;
  logic [31:0] busy_mask;
  logic        sb_err;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rf_write_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .reg_write  (reg_write),
    .wa         (wa),
    .data_write (data_write),
    .grant_id   (grant_id),
    .sb_set     (sb_set),
    .sb_addr    (sb_addr),
    .chk_ra1    (chk_ra1),
    .chk_ra2    (chk_ra2),
    .hazard     (hazard),
    .busy_mask  (busy_mask),
    .sb_err     (sb_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
    req_addr[i*5 +: 5]  = a;
    req_data[i*32 +: 32] = d;
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic [2:0] exp_rdy;
  logic [1:0] exp_gid;

  initial begin
    rst       = 1'b1;
    req_valid = 3'b111;
    req_addr  = '0;
    req_data  = '0;
    sb_set    = 1'b0;
    sb_addr   = '0;
    chk_ra1   = '0;
    chk_ra2   = '0;
    set_req(0, 5'd1, 32'h1111_1111);
    set_req(1, 5'd2, 32'h2222_2222);
    set_req(2, 5'd3, 32'h3333_3333);

    // Reset with every requester valid
    tick();
    tick();
    rst       = 1'b0;
    req_valid = 3'b000;
    #1;
    check("rst_reg_write", {31'd0, reg_write}, 32'd0);
    check("rst_busy",      busy_mask,          32'd0);
    check("rst_sb_err",    {31'd0, sb_err},    32'd0);
    check("rst_wa",        {27'd0, wa},        32'd0);

    // Single execute request
    set_req(0, 5'd5, 32'hDEAD_BEEF);
    req_valid = 3'b001;
    #1;
    check("single_ready", {29'd0, req_ready}, 32'b001);
    tick();
    req_valid = 3'b000;
    check("single_we",   {31'd0, reg_write}, 32'd1);
    check("single_wa",   {27'd0, wa},        32'd5);
    check("single_data", data_write,         32'hDEAD_BEEF);
    check("single_gid",  {30'd0, grant_id},  32'd0);
    tick();
    check("idle_we",   {31'd0, reg_write}, 32'd0);
    check("idle_wa",   {27'd0, wa},        32'd5);
    check("idle_data", data_write,         32'hDEAD_BEEF);

    // Three requesters continuously valid, fresh pointer
    do_reset();
    set_req(0, 5'd1, 32'hA000_0000);
    set_req(1, 5'd2, 32'hA000_0001);
    set_req(2, 5'd3, 32'hA000_0002);
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      #1;
`ifdef RF_ARB_RR_EN
      exp_gid = 2'(k % 3);
`else
      exp_gid = 2'd0;
`endif
      exp_rdy = 3'b001 << exp_gid;
      check($sformatf("arb_ready_%0d", k), {29'd0, req_ready}, {29'd0, exp_rdy});
      tick();
      check($sformatf("arb_gid_%0d", k),  {30'd0, grant_id}, {30'd0, exp_gid});
      check($sformatf("arb_data_%0d", k), data_write, 32'hA000_0000 | {30'd0, exp_gid});
    end
    req_valid = 3'b000;
    tick();

    // Address 0 from the load port: accepted, no write, pointer advances
    do_reset();
    set_req(1, 5'd0, 32'h0BAD_0BAD);
    req_valid = 3'b010;
    #1;
    check("a0_ready", {29'd0, req_ready}, 32'b010);
    tick();
    check("a0_we", {31'd0, reg_write}, 32'd0);
    set_req(1, 5'd2, 32'h2222_2222);
    req_valid = 3'b111;
    #1;
`ifdef RF_ARB_RR_EN
    check("a0_ptr_adv", {29'd0, req_ready}, 32'b100);
`else
    check("a0_ptr_adv", {29'd0, req_ready}, 32'b001);
`endif
    tick();
    req_valid = 3'b000;
    tick();

    // Scoreboard set / hazard / clear / double-set
    do_reset();
    sb_set  = 1'b1;
    sb_addr = 5'd7;
    tick();
    sb_set  = 1'b0;
    check("sb_set7", busy_mask, 32'h0000_0080);
    chk_ra1 = 5'd7;
    chk_ra2 = 5'd0;
    #1;
    check("hz_ra1", {31'd0, hazard}, 32'd1);
    chk_ra1 = 5'd6;
    chk_ra2 = 5'd7;
    #1;
    check("hz_ra2", {31'd0, hazard}, 32'd1);
    chk_ra2 = 5'd0;
    #1;
    check("hz_none", {31'd0, hazard}, 32'd0);
    check("sb_err0", {31'd0, sb_err}, 32'd0);

    set_req(1, 5'd7, 32'h7777_7777);
    req_valid = 3'b010;
    tick();
    req_valid = 3'b000;
    check("ld_clr7",  busy_mask,          32'd0);
    check("ld_we",    {31'd0, reg_write}, 32'd1);
    check("ld_wa",    {27'd0, wa},        32'd7);
    check("ld_gid",   {30'd0, grant_id},  32'd1);

    sb_set  = 1'b1;
    sb_addr = 5'd7;
    tick();
    check("reset7_err0", {31'd0, sb_err}, 32'd0);
    tick();
    sb_set = 1'b0;
    check("dbl_err",  {31'd0, sb_err}, 32'd1);
    check("dbl_busy", busy_mask,       32'h0000_0080);
    sb_set  = 1'b1;
    sb_addr = 5'd0;
    tick();
    sb_set = 1'b0;
    check("x0_ignored", busy_mask,       32'h0000_0080);
    check("err_sticky", {31'd0, sb_err}, 32'd1);
    chk_ra1 = 5'd0;
    #1;
    check("hz_x0", {31'd0, hazard}, 32'd0);

    // Same-cycle set and clear
    do_reset();
    check("rst2_err", {31'd0, sb_err}, 32'd0);
    sb_set  = 1'b1;
    sb_addr = 5'd9;
    tick();
    set_req(1, 5'd9, 32'h9999_9999);
    req_valid = 3'b010;
    tick();
    check("same_busy", busy_mask,       32'h0000_0200);
    check("same_err",  {31'd0, sb_err}, 32'd0);
    sb_addr = 5'd11;
    tick();
    sb_set    = 1'b0;
    req_valid = 3'b000;
    check("diff_busy", busy_mask,       32'h0000_0800);
    check("diff_err",  {31'd0, sb_err}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_rf_write_arbiter
